mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access unit for the RV32I five-stage pipeline. It consumes the EXE/MEM pipeline-register outputs (instruction, ALU address, store data, mem_w, data_to_reg) and drives the data-memory bus through a request/acknowledge handshake. It generates byte enables and aligned store data, and extracts and sign-extends load data. While an access is outstanding it holds the pipeline through `stall`, which the top level inverts into the CE of every pipeline register.

## Interface
Parameters
- TIMEOUT_CYC, 255: maximum cycles in REQ without `dbus_ack` before a bus error is declared; 8-bit counter range (1..255).

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EXE/MEM slot holds a real instruction (0 = bubble)
- ex_inst  in  32  instruction; bits [14:12] are funct3
- ex_addr  in  32  effective address (ALU output)
- ex_wdata  in  32  store data (rs2)
- ex_mem_w  in  1  store
- ex_data_to_reg  in  2  write-back source; 2'b01 = load
- stall  out  1  hold all pipeline registers (combinational)
- dbus_req  out  1  bus request (registered)
- dbus_we  out  1  write strobe
- dbus_addr  out  32  word address, bits [1:0] = 0
- dbus_wdata  out  32  lane-aligned store data
- dbus_be  out  4  byte enables
- dbus_ack  in  1  bus completion, single-cycle pulse
- dbus_rdata  in  32  read word, valid with `dbus_ack`
- ld_data  out  32  extended load result for MEM/WB
- ld_valid  out  1  `ld_data` valid, one-cycle pulse
- bus_err  out  1  timeout pulse
- misalign  out  1  misaligned-access pulse

## Operation
- Access = `ex_valid & (ex_mem_w | ex_data_to_reg==2'b01)`; `ex_mem_w` wins if both are set (treated as a store).
- FSM states are IDLE, REQ, DONE.
  - IDLE → REQ on an aligned access.
  - REQ → DONE on `dbus_ack` or timeout.
  - DONE → IDLE unconditionally.
- `stall` = (IDLE & access) | REQ. In DONE, `stall`=0, so the pipeline advances on the edge that leaves DONE.
- Entering REQ registers `dbus_req`=1, `dbus_we`, `dbus_addr`={addr[31:2],2'b00}, `dbus_be` and `dbus_wdata`. All of these are held stable until the ack cycle.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be=4'b0011<<addr[1:0], wdata = half replicated ×2.
  - SW: be=4'b1111.
- Load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. The lane is selected by addr[1:0], then sign- or zero-extended into `ld_data` on ack.
- Any other funct3 is treated as LW/SW.
- Stores leave `ld_data` unchanged and do not pulse `ld_valid`.
- Timeout: an 8-bit counter clears on REQ entry and increments each REQ cycle. When it reaches TIMEOUT_CYC with no ack, the unit enters DONE with `bus_err`=1, `ld_data`=0 and `ld_valid`=0.
- An ack arriving in IDLE or DONE is ignored.

## Timing
- Reset values of all outputs are 0: `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_wdata`, `dbus_be`, `ld_data`, `ld_valid`, `bus_err`, `misalign`; state = IDLE.
- `stall` resets to 0 as far as the state is concerned; it still follows `ex_*` combinationally.
- Minimum access latency is 3 cycles with the ack in the first REQ cycle: IDLE(stall) → REQ(ack) → DONE(ld_valid).
- `dbus_req` drops in the cycle after the ack edge.
- Deasserting `rst_n` mid-access aborts immediately: `dbus_req`=0 asynchronously, state = IDLE, and no `ld_valid`.
- A bubble or non-memory instruction is never stalled.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) issues no bus request.
  - The unit goes IDLE → DONE directly with `misalign`=1 for one cycle, `ld_data`=0 and `ld_valid`=0.
  - `stall` is high in that IDLE cycle.
- Undefined:
  - `misalign` is tied to 0.
  - Address bits below the access size are ignored: a halfword uses addr[1] only, a word uses lane 0.
  - The access proceeds normally.

## Structure
- Package `rv32_mem_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - DTR_LOAD = 2'b01;
  - the state encoding (IDLE, REQ, DONE);
  - the timeout counter width.
- Sub-module `load_align` is combinational: inputs funct3, addr[1:0] and rdata; output the extended 32-bit value. It is instantiated once.

## Test plan
- LW at 0x100, ack after 2 REQ cycles with rdata 0xDEADBEEF → `stall` high for 3 cycles, `ld_data`=0xDEADBEEF, `ld_valid` pulsed once.
- LB at 0x103, rdata 0x80FF1234 → `ld_data`=0xFFFFFF80. LBU at the same address → `ld_data`=0x00000080.
- SH at 0x202, wdata 0x0000ABCD → `dbus_addr`=0x200, `dbus_be`=4'b1100, `dbus_wdata`=0xABCDABCD, `dbus_we`=1, no `ld_valid`.
- Load with no ack and TIMEOUT_CYC=4 → `bus_err` pulses after 4 REQ cycles, then `stall` releases with `ld_valid`=0.
- LW at 0x101 with `MEM_MISALIGN_TRAP_EN` → `dbus_req` never asserted, `misalign` pulses. Without the macro → access issued to 0x100 with be=4'b1111.
- `rst_n` low in the second REQ cycle → `dbus_req`=0 immediately, state IDLE. An ack arriving after reset release is ignored.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv32_mem_pkg
// Brief    : Shared constants, state encoding and size helpers for the MEM unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] DTR_LOAD = 2'b01;

   localparam int TO_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_t;

   // Stores only know SB/SH/SW; every other funct3 is a word access.
   function automatic acc_size_t acc_size(input logic [2:0] f3, input logic is_store);
      if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_B;
      if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_H;
      return SZ_W;
   endfunction

   function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] lo);
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit_if
// Brief    : Data-memory request/acknowledge bus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_access_unit_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
      input  dbus_ack, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
      output dbus_ack, dbus_rdata
   );
endinterface

`default_nettype wire

// File: rtl/load_align.sv
//------------------------------------------------------------------------------
// Module   : load_align
// Brief    : Selects the load lane from a bus word and sign/zero-extends it.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      // Halfwords honour addr[1] only, so an odd address reads its enclosing half.
      w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   data = {24'h0, w_byte};
         F3_H:    data = {{16{w_half[15]}}, w_half};
         F3_HU:   data = {16'h0, w_half};
         default: data = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : MEM-stage data-memory access unit with req/ack bus and pipeline
//            stall. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
   import rv32_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   input  logic [31:0]        ex_inst,
   input  logic [31:0]        ex_addr,
   input  logic [31:0]        ex_wdata,
   input  logic               ex_mem_w,
   input  logic [1:0]         ex_data_to_reg,
   output logic               stall,
   mem_access_unit_if.master  bus,
   output logic [31:0]        ld_data,
   output logic               ld_valid,
   output logic               bus_err,
   output logic               misalign
);

   localparam logic [TO_CNT_W-1:0] c_to_last = TO_CNT_W'(TIMEOUT_CYC - 1);

   state_t              r_state;
   logic [TO_CNT_W-1:0] r_to_cnt;
   logic [2:0]          r_f3;
   logic [1:0]          r_addr_lo;
   logic                r_is_store;

   logic [2:0]          w_f3;
   logic                w_access;
   logic                w_misal;
   acc_size_t           w_size;
   logic [1:0]          w_off;
   logic [3:0]          w_be;
   logic [31:0]         w_wdata;
   logic [31:0]         w_ld_ext;
   logic                w_unused;

   assign w_f3     = ex_inst[14:12];
   assign w_unused = ^{ex_inst[31:15], ex_inst[11:0]};
   assign w_access = ex_valid & (ex_mem_w | (ex_data_to_reg == DTR_LOAD));
   assign w_size   = acc_size(w_f3, ex_mem_w);

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_misal = is_misaligned(w_size, ex_addr[1:0]);
`else
   assign w_misal = 1'b0;
`endif

   // Address bits below the access size are dropped when choosing the lane.
   always_comb begin
      w_off   = 2'b00;
      w_be    = 4'b1111;
      w_wdata = ex_wdata;
      case (w_size)
         SZ_B: begin
            w_off   = ex_addr[1:0];
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{ex_wdata[7:0]}};
         end
         SZ_H: begin
            w_off   = {ex_addr[1], 1'b0};
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{ex_wdata[15:0]}};
         end
         default: begin
            w_off   = 2'b00;
            w_be    = 4'b1111;
            w_wdata = ex_wdata;
         end
      endcase
   end

   assign stall = ((r_state == IDLE) & w_access) | (r_state == REQ);

   load_align u_load_align (
      .funct3  (r_f3),
      .addr_lo (r_addr_lo),
      .rdata   (bus.dbus_rdata),
      .data    (w_ld_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_to_cnt       <= '0;
         r_f3           <= 3'b000;
         r_addr_lo      <= 2'b00;
         r_is_store     <= 1'b0;
         bus.dbus_req   <= 1'b0;
         bus.dbus_we    <= 1'b0;
         bus.dbus_addr  <= 32'h0;
         bus.dbus_wdata <= 32'h0;
         bus.dbus_be    <= 4'b0000;
         ld_data        <= 32'h0;
         ld_valid       <= 1'b0;
         bus_err        <= 1'b0;
         misalign       <= 1'b0;
      end else begin
         ld_valid <= 1'b0;
         bus_err  <= 1'b0;
         misalign <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_misal) begin
                     r_state  <= DONE;
                     misalign <= 1'b1;
                     ld_data  <= 32'h0;
                  end else begin
                     r_state        <= REQ;
                     r_to_cnt       <= '0;
                     r_f3           <= w_f3;
                     r_addr_lo      <= ex_addr[1:0];
                     r_is_store     <= ex_mem_w;
                     bus.dbus_req   <= 1'b1;
                     bus.dbus_we    <= ex_mem_w;
                     bus.dbus_addr  <= {ex_addr[31:2], 2'b00};
                     bus.dbus_be    <= w_be;
                     bus.dbus_wdata <= ex_mem_w ? w_wdata : 32'h0;
                  end
               end
            end
            REQ: begin
               if (bus.dbus_ack) begin
                  r_state      <= DONE;
                  bus.dbus_req <= 1'b0;
                  bus.dbus_we  <= 1'b0;
                  if (!r_is_store) begin
                     ld_data  <= w_ld_ext;
                     ld_valid <= 1'b1;
                  end
               end else if (r_to_cnt == c_to_last) begin
                  r_state      <= DONE;
                  bus.dbus_req <= 1'b0;
                  bus.dbus_we  <= 1'b0;
                  bus_err      <= 1'b1;
                  ld_data      <= 32'h0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Brief    : Randomized scoreboard bench for mem_access_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_inst = 32'h0;
   logic [31:0] ex_addr = 32'h0;
   logic [31:0] ex_wdata = 32'h0;
   logic        ex_mem_w = 1'b0;
   logic [1:0]  ex_dtr = 2'b00;
   logic        stall, ld_valid, bus_err, misalign;
   logic [31:0] ld_data;

   always #5 clk = ~clk;

   mem_access_unit_if bus_if();

   mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_inst        (ex_inst),
      .ex_addr        (ex_addr),
      .ex_wdata       (ex_wdata),
      .ex_mem_w       (ex_mem_w),
      .ex_data_to_reg (ex_dtr),
      .stall          (stall),
      .bus            (bus_if.master),
      .ld_data        (ld_data),
      .ld_valid       (ld_valid),
      .bus_err        (bus_err),
      .misalign       (misalign)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      int          delay;
      bit          timeout;
      logic [31:0] rdata;
   } req_t;

   typedef struct {
      bit          lv;
      bit          berr;
      bit          mis;
      logic [31:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   resp_en = 1'b1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus slave: checks each request against the model and acks after the chosen delay.
   always begin
      req_t r;
      int   k;
      @(negedge clk);
      if (resp_en && rst_n && bus_if.dbus_req) begin
         if (req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: addr %h issued, none expected", bus_if.dbus_addr);
            k = 0;
            while (bus_if.dbus_req && k < 40) begin
               @(negedge clk);
               k++;
            end
         end else begin
            r = req_q.pop_front();
            check32("dbus_addr", bus_if.dbus_addr, r.addr);
            check32("dbus_be", {28'h0, bus_if.dbus_be}, {28'h0, r.be});
            check32("dbus_we", {31'h0, bus_if.dbus_we}, {31'h0, r.we});
            if (r.we) check32("dbus_wdata", bus_if.dbus_wdata, r.wdata);
            k = 0;
            while (1) begin
               if (!r.timeout && k == r.delay) begin
                  bus_if.dbus_ack   = 1'b1;
                  bus_if.dbus_rdata = r.rdata;
                  @(negedge clk);
                  bus_if.dbus_ack   = 1'b0;
                  bus_if.dbus_rdata = $urandom();
                  check32("req_drop_after_ack", {31'h0, bus_if.dbus_req}, 32'h0);
                  break;
               end
               @(negedge clk);
               k++;
               if (!bus_if.dbus_req || k > 40) break;
            end
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      rsp_t p;
      if (rst_n && (ld_valid || bus_err || misalign)) begin
         if (rsp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: ld_valid=%b bus_err=%b misalign=%b, none expected",
                     ld_valid, bus_err, misalign);
         end else begin
            p = rsp_q.pop_front();
            check32("rsp_flags", {29'h0, ld_valid, bus_err, misalign}, {29'h0, p.lv, p.berr, p.mis});
            check32("ld_data", ld_data, p.data);
         end
      end
   end

   task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int delay, input bit tmo);
      int          sz, off, exp_stall, cnt, idx;
      bit          acc, st, mis;
      logic [31:0] tmp, sh, ldv;
      req_t        r;
      rsp_t        p;

      tmp        = $urandom();
      tmp[14:12] = f3;
      ex_inst    = tmp;
      ex_addr    = addr;
      ex_wdata   = wdata;
      ex_valid   = (kind != 0);
      ex_mem_w   = (kind == 3) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      idx        = $urandom_range(0, 2);
      case (kind)
         1:       ex_dtr = (idx == 0) ? 2'b00 : (idx == 1) ? 2'b10 : 2'b11;
         2:       ex_dtr = 2'b01;
         default: ex_dtr = 2'($urandom_range(0, 3));
      endcase

      acc = (kind >= 2);
      st  = (kind == 3);
      if (st) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = (int'(addr[1:0]) % sz) != 0;
`else
      mis = 1'b0;
`endif
      off = int'(addr[1:0]) - (int'(addr[1:0]) % sz);

      exp_stall = 0;
      if (acc && mis) begin
         p = '{lv: 0, berr: 0, mis: 1, data: 32'h0};
         rsp_q.push_back(p);
         exp_stall = 1;
      end else if (acc) begin
         r.addr    = addr & 32'hFFFF_FFFC;
         r.be      = 4'(((1 << sz) - 1) << off);
         r.we      = st;
         r.wdata   = (sz == 1) ? wdata[7:0] * 32'h0101_0101 :
                     (sz == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
         r.delay   = delay;
         r.timeout = tmo;
         r.rdata   = rdata;
         req_q.push_back(r);
         exp_stall = 1 + (tmo ? TO : delay + 1);
         if (tmo) begin
            p = '{lv: 0, berr: 1, mis: 0, data: 32'h0};
            rsp_q.push_back(p);
         end else if (!st) begin
            sh = rdata >> (8 * off);
            case (f3)
               3'd0:    ldv = {{24{sh[7]}}, sh[7:0]};
               3'd4:    ldv = {24'h0, sh[7:0]};
               3'd1:    ldv = {{16{sh[15]}}, sh[15:0]};
               3'd5:    ldv = {16'h0, sh[15:0]};
               default: ldv = rdata;
            endcase
            p = '{lv: 1, berr: 0, mis: 0, data: ldv};
            rsp_q.push_back(p);
         end
      end

      cnt = 0;
      while (1) begin
         @(negedge clk);
         if (!stall) break;
         cnt++;
         if (cnt > 60) break;
      end
      check32("stall_cycles", cnt, exp_stall);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus_if.dbus_ack   = 1'b0;
      bus_if.dbus_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check32("rst_req", {31'h0, bus_if.dbus_req}, 32'h0);
      check32("rst_we", {31'h0, bus_if.dbus_we}, 32'h0);
      check32("rst_addr", bus_if.dbus_addr, 32'h0);
      check32("rst_wdata", bus_if.dbus_wdata, 32'h0);
      check32("rst_be", {28'h0, bus_if.dbus_be}, 32'h0);
      check32("rst_ld", {ld_data[31:4], ld_data[3:0] | {ld_valid, bus_err, misalign, stall}}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_txn(2, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 0);
      run_txn(2, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
      run_txn(2, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2, 0);
      run_txn(3, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0);
      run_txn(2, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 0, 1);
      run_txn(3, 3'd2, 32'h0000_0044, 32'h1234_5678, 32'h0, 0, 1);
      run_txn(2, 3'd2, 32'h0000_0101, 32'h0, 32'h1122_3344, 0, 0);
      run_txn(2, 3'd2, 32'h0000_0104, 32'h0, 32'h5566_7788, TO - 1, 0);

      for (int i = 0; i < 300; i++) begin
         run_txn($urandom_range(0, 3), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                 $urandom(), $urandom_range(0, TO - 1), ($urandom_range(0, 9) == 0));
      end

      // Reset in the second REQ cycle, then a stray ack after release.
      resp_en  = 1'b0;
      ex_inst  = 32'h0000_2003;
      ex_addr  = 32'h0000_0100;
      ex_mem_w = 1'b0;
      ex_dtr   = 2'b01;
      ex_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check32("abort_req_before", {31'h0, bus_if.dbus_req}, 32'h1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check32("abort_req_async", {31'h0, bus_if.dbus_req}, 32'h0);
      ex_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      bus_if.dbus_ack   = 1'b1;
      bus_if.dbus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus_if.dbus_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check32("abort_no_ld_valid", {31'h0, ld_valid}, 32'h0);
         check32("abort_no_req", {31'h0, bus_if.dbus_req}, 32'h0);
         @(negedge clk);
      end

      check32("rsp_q_empty", rsp_q.size(), 32'h0);
      check32("req_q_empty", req_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
